// File: rtl/mandelbrot_px_recirc.sv
// Loop controller behind the fractal math stage: seeds the math input FIFO
// with one zero record per pixel, then recirculates math output records
// back into the input FIFO while mirroring each pixel value into the
// framebuffer at its raster address.
//
// Ports:
//   i_Clk, i_Rst_n            clock, synchronous active-low reset
//   i_Src_Data/i_Src_Empty    show-ahead head of math output FIFO
//   o_Src_Ack                 pop math output FIFO
//   o_Dst_Data/o_Dst_Wrreq    write port of math input FIFO
//   i_Dst_Full                math input FIFO full
//   o_Fb_We/Addr/Data         registered framebuffer write
//   o_Frame_Done              pulse with the last pixel write of a pass
//   o_Pass_Count              completed passes (wrapping)
//   o_Seeding                 high while seeding
module mandelbrot_px_recirc #(
    parameter int H_PIXELS = 800,
    parameter int V_PIXELS = 480,
    parameter int N_PIXELS = H_PIXELS * V_PIXELS
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic [103:0] i_Src_Data,
    input  logic         i_Src_Empty,
    output logic         o_Src_Ack,
    output logic [103:0] o_Dst_Data,
    input  logic         i_Dst_Full,
    output logic         o_Dst_Wrreq,
    output logic         o_Fb_We,
    output logic [18:0]  o_Fb_Addr,
    output logic [7:0]   o_Fb_Data,
    output logic         o_Frame_Done,
    output logic [15:0]  o_Pass_Count,
    output logic         o_Seeding
);

    localparam logic [18:0] LAST = 19'(N_PIXELS - 1);

    typedef enum logic {
        SEED,
        RUN
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [18:0] seed_cnt_q;
    logic [18:0] seed_cnt_d;
    logic [18:0] pix_cnt_q;
    logic [18:0] pix_cnt_d;
    logic        move;

    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        move        = 1'b0;
        o_Src_Ack   = 1'b0;
        o_Dst_Wrreq = 1'b0;
        o_Dst_Data  = '0;
        // Handshakes stay quiet while reset is asserted so neither FIFO
        // sees a stray pop or push on the reset edge.
        if (i_Rst_n) begin
            unique case (state_q)
                SEED: begin
                    o_Dst_Wrreq = ~i_Dst_Full;
                    if (!i_Dst_Full) begin
                        if (seed_cnt_q == LAST) begin
                            state_d    = RUN;
                            seed_cnt_d = '0;
                        end else begin
                            seed_cnt_d = seed_cnt_q + 19'd1;
                        end
                    end
                end
                RUN: begin
                    move        = ~i_Src_Empty & ~i_Dst_Full;
                    o_Src_Ack   = move;
                    o_Dst_Wrreq = move;
                    o_Dst_Data  = i_Src_Data;
                    if (move) begin
                        pix_cnt_d = (pix_cnt_q == LAST) ? '0
                                  : pix_cnt_q + 19'd1;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= SEED;
            seed_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            o_Fb_We      <= 1'b0;
            o_Fb_Addr    <= '0;
            o_Fb_Data    <= '0;
            o_Frame_Done <= 1'b0;
            o_Pass_Count <= '0;
        end else begin
            state_q      <= state_d;
            seed_cnt_q   <= seed_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            o_Fb_We      <= move;
            o_Frame_Done <= move & (pix_cnt_q == LAST);
            if (move) begin
                o_Fb_Addr <= pix_cnt_q;
                o_Fb_Data <= i_Src_Data[103:96];
            end
            if (move && pix_cnt_q == LAST) begin
                o_Pass_Count <= o_Pass_Count + 16'd1;
            end
        end
    end

    assign o_Seeding = (state_q == SEED);

endmodule

// File: doc/mandelbrot_px_recirc.md
# mandelbrot_px_recirc

Loop controller on the far side of the fractal math stage. After reset it seeds the math stage's input FIFO with one zero record per screen pixel, in raster order. It then recirculates every record leaving the math stage's output FIFO back into its input FIFO. Each recirculated pixel value is mirrored into the framebuffer at its raster address.

## Interface
Parameters:
- H_PIXELS, 800, pixels per line
- V_PIXELS, 480, lines per frame
- N_PIXELS, H_PIXELS*V_PIXELS (384000), records per pass

Ports:
- i_Clk  in  1  system clock
- i_Rst_n  in  1  synchronous, active-low reset
- i_Src_Data  in  104  head record of math output FIFO (show-ahead): {PxVal[7:0], X[31:0], Y[31:0], Iteration[31:0]}
- i_Src_Empty  in  1  math output FIFO empty
- o_Src_Ack  out  1  pop math output FIFO this cycle
- o_Dst_Data  out  104  record to math input FIFO
- i_Dst_Full  in  1  math input FIFO full
- o_Dst_Wrreq  out  1  write math input FIFO this cycle
- o_Fb_We  out  1  framebuffer write strobe (registered)
- o_Fb_Addr  out  19  framebuffer linear address = y*H_PIXELS + x (registered)
- o_Fb_Data  out  8  pixel value, bits [103:96] of the recirculated record (registered)
- o_Frame_Done  out  1  one-cycle pulse accompanying the framebuffer write of the last pixel of a pass
- o_Pass_Count  out  16  completed recirculation passes; wraps 0xFFFF -> 0
- o_Seeding  out  1  high while in SEED

## Operation
State machine, two states:
- SEED, entered on reset.
  - seed_cnt counts 0..N_PIXELS-1.
  - o_Dst_Data = 104'h0 and o_Dst_Wrreq = ~i_Dst_Full.
  - seed_cnt increments on each write.
  - o_Src_Ack = 0 and no framebuffer writes.
  - After the write with seed_cnt == N_PIXELS-1, go to RUN next cycle.
- RUN.
  - move = ~i_Src_Empty & ~i_Dst_Full.
  - o_Src_Ack = o_Dst_Wrreq = move, both combinational.
  - o_Dst_Data = i_Src_Data, passed through unmodified.
  - pix_cnt (19 bits) is the raster index of the head record.
  - On move: pix_cnt increments. At N_PIXELS-1 it wraps to 0 instead.
  - RUN never exits except by reset.
- Record order is strictly preserved. The math stage derives pixel coordinates by counting acknowledged records, so a record is never dropped, duplicated or reordered.
- Framebuffer mirror, registered, sampled on move:
  - o_Fb_We <= move.
  - o_Fb_Addr <= pix_cnt.
  - o_Fb_Data <= i_Src_Data[103:96].
  - o_Frame_Done <= move & (pix_cnt == N_PIXELS-1).
  - o_Pass_Count increments on the same edge as that o_Frame_Done assertion.
- When o_Fb_We is low, o_Fb_Addr and o_Fb_Data hold their last values.

## Timing
- Reset values, all applied at the first clock edge with i_Rst_n low:
  - state = SEED, seed_cnt = 0, pix_cnt = 0.
  - o_Fb_We = 0, o_Fb_Addr = 0, o_Fb_Data = 0.
  - o_Frame_Done = 0, o_Pass_Count = 0, o_Seeding = 1.
  - Combinational outputs are held inactive during reset: o_Src_Ack = 0, o_Dst_Wrreq = 0.
- Throughput is one record per cycle in both states while the FIFOs permit. SEED takes N_PIXELS cycles plus one cycle per full-stall cycle.
- FIFO handshakes:
  - Src pops on the edge where o_Src_Ack = 1. i_Src_Data is valid whenever i_Src_Empty = 0.
  - Dst captures o_Dst_Data on the edge where o_Dst_Wrreq = 1.
- Framebuffer write latency is one cycle after the move edge.
- Simultaneous empty and full: no move, no state change.
- Reset mid-operation returns to SEED and reseeds from 0. The same reset must flush both FIFOs and clear the math stage's pixel counters. The system owns that requirement; this block does not check it.
- Full during SEED stalls seed_cnt with no write. Full never causes data loss.
- o_Pass_Count wraps silently.

## Test plan
- Reset, then Dst never full: exactly 384000 writes of 104'h0 in cycles 0..383999. o_Seeding falls and RUN begins at cycle 384000. o_Src_Ack stays 0 throughout SEED.
- SEED with i_Dst_Full toggling every other cycle: the write count is still exactly 384000, and no write occurs in any full cycle.
- RUN with src presenting record {8'h85, X, Y, 32'd3} at pix_cnt 801:
  - o_Dst_Data equals the input record in the same cycle.
  - The next cycle gives o_Fb_We = 1, o_Fb_Addr = 801, o_Fb_Data = 8'h85.
- Full pass through a loopback FIFO model: o_Frame_Done pulses once, alongside o_Fb_Addr = 383999. o_Pass_Count steps 0 -> 1. The next framebuffer address is 0.
- i_Src_Empty = 1 with i_Dst_Full = 0, then the reverse: o_Src_Ack = o_Dst_Wrreq = 0 and pix_cnt is frozen. Order is preserved after the stall is released.
- i_Rst_n pulsed low for 1 cycle mid-RUN at pix_cnt 1000: the next cycle shows o_Seeding = 1 and o_Fb_We = 0. Seeding restarts at seed_cnt 0, and o_Pass_Count reads 0.
